// File: rtl/brick_field.sv
// Brick grid state and per-frame ball/brick collision engine; BRICK_SCORE_EN adds a saturating score counter.
// Latency: a hit at corner k clears its brick at E0+1+k with hit_pulse in the same cycle; busy at most 5 cycles; no backpressure.
module brick_field #(
    parameter int COLS      = 10,
    parameter int ROWS      = 5,
    parameter int BRICK_W   = 64,
    parameter int BRICK_H   = 16,
    parameter int TOP_Y     = 40,
    parameter int BALL_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   reload,
    input  logic [9:0]             ball_x,
    input  logic [9:0]             ball_y,
    output logic [ROWS*COLS-1:0]   brick_state,
    output logic                   hit_pulse,
    output logic [5:0]             hit_index,
    output logic                   all_clear,
    output logic [15:0]            score
);

    localparam int          NB     = ROWS * COLS;
    localparam int          XSH    = $clog2(BRICK_W);
    localparam int          YSH    = $clog2(BRICK_H);
    localparam logic [10:0] GRID_W = 11'(COLS * BRICK_W);
    localparam logic [10:0] TOP_L  = 11'(TOP_Y);
    localparam logic [10:0] BOT_L  = 11'(TOP_Y + ROWS * BRICK_H);
    localparam logic [10:0] OFS    = 11'(BALL_SIZE - 1);
    localparam logic [10:0] COLS_L = 11'(COLS);

    typedef enum logic [1:0] {IDLE, CHECK, HIT} state_t;

    state_t          state_q, state_d;
    logic [10:0]     bx_q, bx_d, by_q, by_d;
    logic [1:0]      corner_q, corner_d;
    logic [NB-1:0]   brick_state_q, brick_state_d;
    logic            hit_pulse_q, hit_pulse_d;
    logic [5:0]      hit_index_q, hit_index_d;
    logic            all_clear_q, all_clear_d;

    logic [10:0]     cx, cy, dy, col_w, row_w;
    logic [5:0]      idx_w;
    logic            in_grid;
    logic [NB-1:0]   alive_vec;

    // Corner k selects +BALL_SIZE-1 on x with bit 0 and on y with bit 1.
    always_comb begin
        cx        = bx_q + (corner_q[0] ? OFS : 11'd0);
        cy        = by_q + (corner_q[1] ? OFS : 11'd0);
        dy        = cy - TOP_L;
        col_w     = cx >> XSH;
        row_w     = dy >> YSH;
        idx_w     = 6'(row_w * COLS_L + col_w);
        in_grid   = (cx < GRID_W) && (cy >= TOP_L) && (cy < BOT_L);
        alive_vec = brick_state_q >> idx_w;
    end

`ifdef BRICK_SCORE_EN
    logic [5:0]  hit_row_q, hit_row_d;
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum;
`endif

    always_comb begin
        state_d       = state_q;
        bx_d          = bx_q;
        by_d          = by_q;
        corner_d      = corner_q;
        brick_state_d = brick_state_q;
        hit_pulse_d   = 1'b0;
        hit_index_d   = hit_index_q;
`ifdef BRICK_SCORE_EN
        hit_row_d     = hit_row_q;
        score_d       = score_q;
        score_sum     = {1'b0, score_q} + 17'(ROWS) - 17'(hit_row_q);
`endif
        if (reload) begin
            brick_state_d = '1;
            state_d       = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        bx_d     = {1'b0, ball_x};
                        by_d     = {1'b0, ball_y};
                        corner_d = 2'd0;
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    if (in_grid && alive_vec[0]) begin
                        brick_state_d = brick_state_q & ~(NB'(1) << idx_w);
                        hit_index_d   = idx_w;
                        hit_pulse_d   = 1'b1;
                        state_d       = HIT;
`ifdef BRICK_SCORE_EN
                        hit_row_d     = row_w[5:0];
`endif
                    end else begin
                        corner_d = corner_q + 2'd1;
                        if (corner_q == 2'd3) begin
                            state_d = IDLE;
                        end
                    end
                end
                HIT: begin
                    state_d = IDLE;
`ifdef BRICK_SCORE_EN
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        all_clear_d = (brick_state_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bx_q          <= '0;
            by_q          <= '0;
            corner_q      <= '0;
            brick_state_q <= '1;
            hit_pulse_q   <= 1'b0;
            hit_index_q   <= '0;
            all_clear_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            corner_q      <= corner_d;
            brick_state_q <= brick_state_d;
            hit_pulse_q   <= hit_pulse_d;
            hit_index_q   <= hit_index_d;
            all_clear_q   <= all_clear_d;
        end
    end

`ifdef BRICK_SCORE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_row_q <= '0;
            score_q   <= '0;
        end else begin
            hit_row_q <= hit_row_d;
            score_q   <= score_d;
        end
    end
    assign score = score_q;
`else
    assign score = 16'd0;
`endif

    assign brick_state = brick_state_q;
    assign hit_pulse   = hit_pulse_q;
    assign hit_index   = hit_index_q;
    assign all_clear   = all_clear_q;

endmodule

// File: tb/tb_brick_field.sv
// Directed + randomized bench for brick_field against a per-frame reference model of the brick grid.
module tb_brick_field;

    logic        clk = 1'b0;
    logic        rst, frame_tick, reload;
    logic [9:0]  ball_x, ball_y;
    logic [49:0] brick_state;
    logic        hit_pulse;
    logic [5:0]  hit_index;
    logic        all_clear;
    logic [15:0] score;

    brick_field dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .reload(reload),
        .ball_x(ball_x), .ball_y(ball_y), .brick_state(brick_state),
        .hit_pulse(hit_pulse), .hit_index(hit_index), .all_clear(all_clear),
        .score(score)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [49:0] m_alive;
    int          m_score;
    int          m_last_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_score();
`ifdef BRICK_SCORE_EN
        return m_score;
`else
        return 0;
`endif
    endfunction

    // First corner (0..3) that lands on a live brick, or -1.
    function automatic int model_hit(input int x, input int y, output int idx);
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            int cx, cy;
            cx = x + ((k % 2 == 1) ? 7 : 0);
            cy = y + ((k / 2 == 1) ? 7 : 0);
            if (cx < 640 && cy >= 40 && cy < 120) begin
                idx = ((cy - 40) / 16) * 10 + cx / 64;
                if (m_alive[idx]) return k;
            end
        end
        return -1;
    endfunction

    task automatic do_frame(input int x, input int y, input string tag);
        int k, idx;
        k = model_hit(x, y, idx);
        ball_x = 10'(x);
        ball_y = 10'(y);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (k >= 0 && c == k + 1) begin
                m_alive[idx] = 1'b0;
                m_last_idx   = idx;
                m_score      = m_score + (5 - idx / 10);
                if (m_score > 65535) m_score = 65535;
            end
            check({tag, "_pulse"}, 64'(hit_pulse), 64'(k >= 0 && c == k + 1));
            check({tag, "_state"}, 64'(brick_state), 64'(m_alive));
        end
        check({tag, "_index"}, 64'(hit_index), 64'(m_last_idx));
        check({tag, "_clear"}, 64'(all_clear), 64'(m_alive == 50'd0));
        check({tag, "_score"}, 64'(score), 64'(exp_score()));
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        m_alive = '1;
        check("reload_state", 64'(brick_state), 64'(m_alive));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst = 1'b1; frame_tick = 1'b0; reload = 1'b0; ball_x = '0; ball_y = '0;
        m_alive = '1; m_score = 0; m_last_idx = 0;
        #12;
        check("rst_state", 64'(brick_state), 64'h3_FFFF_FFFF_FFFF);
        check("rst_pulse", 64'(hit_pulse), 64'd0);
        check("rst_index", 64'(hit_index), 64'd0);
        check("rst_clear", 64'(all_clear), 64'd0);
        check("rst_score", 64'(score), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("idle_pulse", 64'(hit_pulse), 64'd0);
            check("idle_state", 64'(brick_state), 64'h3_FFFF_FFFF_FFFF);
        end

        do_frame(0, 40, "t1");

        do_reload();
        do_frame(60, 52, "t2a");
        repeat (4) @(posedge clk);
        #1;
        do_frame(60, 52, "t2b");
        check("t2b_index1", 64'(hit_index), 64'd1);

        do_frame(300, 400, "t3");

        // Reload held across the second tick so that tick must be dropped.
        ball_x = 10'd0; ball_y = 10'd40; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0; reload = 1'b1;
        @(posedge clk); #1;
        check("t4_pulse_e1", 64'(hit_pulse), 64'd0);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0; reload = 1'b0;
        m_alive = '1;
        repeat (5) begin
            @(posedge clk); #1;
            check("t4_pulse", 64'(hit_pulse), 64'd0);
            check("t4_state", 64'(brick_state), 64'(m_alive));
        end
        check("t4_score", 64'(score), 64'(exp_score()));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) do_reload();
            do_frame(int'($urandom_range(0, 660)), int'($urandom_range(20, 140)), "rnd");
        end

        do_reload();
        s0 = exp_score();
        for (int i = 0; i < 50; i++) begin
            do_frame((i % 10) * 64, 40 + (i / 10) * 16, "sweep");
        end
        check("sweep_all_clear", 64'(all_clear), 64'd1);
`ifdef BRICK_SCORE_EN
        check("sweep_score", 64'(score), 64'((s0 + 150 > 65535) ? 65535 : s0 + 150));
`else
        check("sweep_score", 64'(score), 64'(s0));
`endif

        // Asynchronous reset in the middle of a frame.
        do_reload();
        ball_x = 10'd128; ball_y = 10'd56; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_state", 64'(brick_state), 64'h3_FFFF_FFFF_FFFF);
        check("arst_pulse", 64'(hit_pulse), 64'd0);
        check("arst_index", 64'(hit_index), 64'd0);
        check("arst_score", 64'(score), 64'd0);
        @(negedge clk); rst = 1'b0;
        m_alive = '1; m_score = 0; m_last_idx = 0;
        do_frame(128, 56, "post_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
